// File: rtl/fluid_pkg.sv
// Shared constants for the fluid dispenser controller: fluid codes, status codes,
// FSM states, unit-rate table and visit-based discount schedule.
package fluid_pkg;

  localparam logic [1:0] F_WATER = 2'd0;
  localparam logic [1:0] F_JUICE = 2'd1;
  localparam logic [1:0] F_CHEM  = 2'd2;
  localparam logic [1:0] F_INV   = 2'd3;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_NOSTOCK  = 2'd1,
    ST_BADFLUID = 2'd2,
    ST_ZEROVOL  = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DISP = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [7:0] DISC_T1 = 8'd2;
  localparam logic [7:0] DISC_T2 = 8'd4;
  localparam logic [6:0] DISC_P1 = 7'd10;
  localparam logic [6:0] DISC_P2 = 7'd20;

  function automatic logic [7:0] first_rate(input logic [1:0] f);
    case (f)
      F_WATER: first_rate = 8'd20;
      F_JUICE: first_rate = 8'd50;
      F_CHEM:  first_rate = 8'd40;
      default: first_rate = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] follow_rate(input logic [1:0] f);
    case (f)
      F_WATER: follow_rate = 8'd10;
      F_JUICE: follow_rate = 8'd30;
      F_CHEM:  follow_rate = 8'd20;
      default: follow_rate = 8'd0;
    endcase
  endfunction

  // Discount keys off the visit count seen before this purchase is recorded.
  function automatic logic [6:0] disc_pct(input logic [7:0] visits);
    if (visits <= DISC_T1)      disc_pct = 7'd0;
    else if (visits <= DISC_T2) disc_pct = DISC_P1;
    else                        disc_pct = DISC_P2;
  endfunction

endpackage

// File: rtl/visit_counter_bank.sv
// Per-user saturating visit counters with one combinational read port and
// one increment strobe.
module visit_counter_bank
  #(parameter int NUM_USERS = 16,
    parameter int VISIT_W   = 4,
    parameter int USER_W    = $clog2(NUM_USERS))
  (
    input  logic              clk,
    input  logic              reset,
    input  logic [USER_W-1:0] rd_user,
    output logic [VISIT_W-1:0] rd_count,
    input  logic              inc,
    input  logic [USER_W-1:0] inc_user
  );

  logic [NUM_USERS-1:0][VISIT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      for (int u = 0; u < NUM_USERS; u++)
        if (inc && inc_user == USER_W'(u) && cnt[u] != '1)
          cnt[u] <= cnt[u] + 1'b1;
    end
  end

  assign rd_count = cnt[rd_user];

endmodule

// File: rtl/fluid_dispense_ctrl.sv
// Sequential fluid dispenser: request/response handshakes, live per-fluid stock
// with refills, per-litre valve pulses and visit-based discounting.
module fluid_dispense_ctrl
  import fluid_pkg::*;
  #(parameter int NUM_USERS  = 16,
    parameter int USER_W     = $clog2(NUM_USERS),
    parameter int VISIT_W    = 4,
    parameter int VOL_W      = 8,
    parameter int PRICE_W    = 16,
    parameter int STOCK_W    = 16,
    parameter int INIT_WATER = 100,
    parameter int INIT_JUICE = 80,
    parameter int INIT_CHEM  = 60,
    parameter int LOW_THRESH = 10)
  (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [USER_W-1:0]  req_user,
    input  logic [1:0]         req_fluid,
    input  logic [VOL_W-1:0]   req_vol,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [1:0]         resp_status,
    output logic [PRICE_W-1:0] resp_orig_price,
    output logic [PRICE_W-1:0] resp_final_price,
    output logic [6:0]         resp_disc,
    output logic [STOCK_W-1:0] resp_remaining,
    output logic [VISIT_W-1:0] resp_visits,
    output logic               valve_open,
    output logic [1:0]         valve_fluid,
    input  logic               refill_valid,
    output logic               refill_ready,
    input  logic [1:0]         refill_fluid,
    input  logic [STOCK_W-1:0] refill_amt,
    output logic [2:0]         stock_low
  );

  localparam int PW = PRICE_W + 7;

  state_e                   state;
  logic                     idle_rdy;
  logic [USER_W-1:0]        user_q;
  logic [1:0]               fluid_q;
  logic [VOL_W-1:0]         vol_q;
  logic [VOL_W-1:0]         cnt_q;
  logic [2:0][STOCK_W-1:0]  stock;

  logic [VISIT_W-1:0]       prior_vis;
  logic                     vis_inc;
  logic [STOCK_W-1:0]       cur_stock;
  logic [STOCK_W-1:0]       ref_cur;
  logic [STOCK_W:0]         ref_sum;
  logic [STOCK_W-1:0]       ref_new;
  status_e                  calc_status;
  logic [PRICE_W-1:0]       orig_price;
  logic [6:0]               disc;
  logic [PW-1:0]            disc_amt;
  logic [PRICE_W-1:0]       final_price;

  // ready is held low for the first cycle out of reset so no handshake
  // completes while the block is still reinitialising
  assign refill_ready = idle_rdy;
  assign req_ready    = idle_rdy & ~refill_valid;

  // the count bumps on the last dispense edge, i.e. on entry to RESP
  assign vis_inc = (state == S_DISP) && (cnt_q == VOL_W'(1));

  visit_counter_bank #(
    .NUM_USERS (NUM_USERS),
    .VISIT_W   (VISIT_W),
    .USER_W    (USER_W)
  ) u_visits (
    .clk      (clk),
    .reset    (reset),
    .rd_user  (user_q),
    .rd_count (prior_vis),
    .inc      (vis_inc),
    .inc_user (user_q)
  );

  always_comb begin
    cur_stock = '0;
    case (fluid_q)
      F_WATER: cur_stock = stock[0];
      F_JUICE: cur_stock = stock[1];
      F_CHEM:  cur_stock = stock[2];
      default: cur_stock = '0;
    endcase
  end

  always_comb begin
    ref_cur = '0;
    case (refill_fluid)
      F_WATER: ref_cur = stock[0];
      F_JUICE: ref_cur = stock[1];
      F_CHEM:  ref_cur = stock[2];
      default: ref_cur = '0;
    endcase
    ref_sum = {1'b0, ref_cur} + {1'b0, refill_amt};
    ref_new = ref_sum[STOCK_W] ? '1 : ref_sum[STOCK_W-1:0];
  end

  always_comb begin
    if (fluid_q == F_INV)                  calc_status = ST_BADFLUID;
    else if (vol_q == '0)                  calc_status = ST_ZEROVOL;
    else if (STOCK_W'(vol_q) > cur_stock)  calc_status = ST_NOSTOCK;
    else                                   calc_status = ST_OK;
  end

  always_comb begin
    orig_price  = PRICE_W'(first_rate(fluid_q))
                + PRICE_W'(follow_rate(fluid_q)) * PRICE_W'(vol_q - 1'b1);
    disc        = disc_pct(8'(prior_vis));
    disc_amt    = (PW'(orig_price) * PW'(disc)) / PW'(100);
    final_price = orig_price - PRICE_W'(disc_amt);
  end

  always_comb begin
    stock_low[0] = stock[0] < STOCK_W'(LOW_THRESH);
    stock_low[1] = stock[1] < STOCK_W'(LOW_THRESH);
    stock_low[2] = stock[2] < STOCK_W'(LOW_THRESH);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= S_IDLE;
      idle_rdy         <= 1'b0;
      user_q           <= '0;
      fluid_q          <= '0;
      vol_q            <= '0;
      cnt_q            <= '0;
      stock[0]         <= STOCK_W'(INIT_WATER);
      stock[1]         <= STOCK_W'(INIT_JUICE);
      stock[2]         <= STOCK_W'(INIT_CHEM);
      resp_valid       <= 1'b0;
      resp_status      <= '0;
      resp_orig_price  <= '0;
      resp_final_price <= '0;
      resp_disc        <= '0;
      resp_remaining   <= '0;
      resp_visits      <= '0;
      valve_open       <= 1'b0;
      valve_fluid      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          idle_rdy <= 1'b1;
          if (idle_rdy && refill_valid) begin
            for (int i = 0; i < 3; i++)
              if (refill_fluid == 2'(i)) stock[i] <= ref_new;
          end else if (idle_rdy && req_valid) begin
            user_q   <= req_user;
            fluid_q  <= req_fluid;
            vol_q    <= req_vol;
            idle_rdy <= 1'b0;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          resp_status <= calc_status;
          if (calc_status != ST_OK) begin
            resp_orig_price  <= '0;
            resp_final_price <= '0;
            resp_disc        <= '0;
            resp_remaining   <= cur_stock;
            resp_visits      <= prior_vis;
            resp_valid       <= 1'b1;
            state            <= S_RESP;
          end else begin
            resp_orig_price  <= orig_price;
            resp_final_price <= final_price;
            resp_disc        <= disc;
            resp_remaining   <= cur_stock - STOCK_W'(vol_q);
            resp_visits      <= (prior_vis == '1) ? prior_vis : prior_vis + 1'b1;
            cnt_q            <= vol_q;
            valve_open       <= 1'b1;
            valve_fluid      <= fluid_q;
            state            <= S_DISP;
          end
        end
        S_DISP: begin
          for (int i = 0; i < 3; i++)
            if (fluid_q == 2'(i)) stock[i] <= stock[i] - 1'b1;
          if (cnt_q == VOL_W'(1)) begin
            valve_open <= 1'b0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            idle_rdy   <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fluid_dispense_ctrl.sv
// Directed bench for fluid_dispense_ctrl with hand-computed expectations.
module tb_fluid_dispense_ctrl;
  import fluid_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_user;
  logic [1:0]  req_fluid;
  logic [7:0]  req_vol;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_status;
  logic [15:0] resp_orig_price, resp_final_price;
  logic [6:0]  resp_disc;
  logic [15:0] resp_remaining;
  logic [3:0]  resp_visits;
  logic        valve_open;
  logic [1:0]  valve_fluid;
  logic        refill_valid, refill_ready;
  logic [1:0]  refill_fluid;
  logic [15:0] refill_amt;
  logic [2:0]  stock_low;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fluid_dispense_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_user(req_user),
    .req_fluid(req_fluid), .req_vol(req_vol),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
    .resp_orig_price(resp_orig_price), .resp_final_price(resp_final_price),
    .resp_disc(resp_disc), .resp_remaining(resp_remaining), .resp_visits(resp_visits),
    .valve_open(valve_open), .valve_fluid(valve_fluid),
    .refill_valid(refill_valid), .refill_ready(refill_ready),
    .refill_fluid(refill_fluid), .refill_amt(refill_amt), .stock_low(stock_low)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] resp_snap();
    return {3'd0, resp_status, resp_orig_price, resp_final_price, resp_disc,
            resp_remaining, resp_visits};
  endfunction

  // Issue one request, measure latency and valve pulses, check the response,
  // optionally stall the consumer for `hold` cycles, then retire it.
  task automatic run_req(input string tag, input logic [3:0] user, input logic [1:0] fluid,
                         input logic [7:0] vol, input int st, input int orig, input int dsc,
                         input int fin, input int rem, input int vis, input int hold);
    int n, lat, nv;
    logic [63:0] snap;
    @(negedge clk);
    req_valid = 1'b1; req_user = user; req_fluid = fluid; req_vol = vol;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk({tag, " accept_timeout"}, 0, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; nv = 0;
    while (!resp_valid && lat < 400) begin
      nv += int'(valve_open);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, (st == 0) ? 2 + int'(vol) : 2);
    chk({tag, " valve_cycles"}, nv, (st == 0) ? int'(vol) : 0);
    chk({tag, " status"}, resp_status, st);
    chk({tag, " orig"}, resp_orig_price, orig);
    chk({tag, " disc"}, resp_disc, dsc);
    chk({tag, " final"}, resp_final_price, fin);
    chk({tag, " remaining"}, resp_remaining, rem);
    chk({tag, " visits"}, resp_visits, vis);
    snap = resp_snap();
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, " hold_valid"}, resp_valid, 1);
      chk({tag, " hold_fields"}, resp_snap(), snap);
      chk({tag, " hold_req_ready"}, req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, " resp_drop"}, resp_valid, 0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_user = '0; req_fluid = '0; req_vol = '0;
    resp_ready = 1'b0; refill_valid = 1'b0; refill_fluid = '0; refill_amt = '0;
    repeat (3) @(negedge clk);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst valve_open", valve_open, 0);
    chk("rst req_ready", req_ready, 0);
    chk("rst refill_ready", refill_ready, 0);
    chk("rst status", resp_status, 0);
    chk("rst stock_low", stock_low, 3'b000);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle req_ready", req_ready, 1);
    chk("idle refill_ready", refill_ready, 1);

    //      tag       user fl  vol st orig dsc fin  rem   vis hold
    run_req("water3", 5, 0, 3,  0, 40,  0,  40,  97,   1, 0);
    run_req("juice#1", 2, 1, 2,  0, 80,  0,  80,  78,   1, 0);
    run_req("juice#2", 2, 1, 2,  0, 80,  0,  80,  76,   2, 0);
    run_req("juice#3", 2, 1, 2,  0, 80,  0,  80,  74,   3, 0);
    run_req("juice#4", 2, 1, 2,  0, 80,  10, 72,  72,   4, 0);
    run_req("juice#5", 2, 1, 1,  0, 50,  10, 45,  71,   5, 0);
    run_req("juice#6", 2, 1, 1,  0, 50,  20, 40,  70,   6, 0);
    run_req("chem61", 7, 2, 61, 1, 0,   0,  0,   60,   0, 0);
    run_req("fluid11", 5, 3, 4,  2, 0,   0,  0,   0,    1, 0);
    run_req("water0", 5, 0, 0,  3, 0,   0,  0,   97,   1, 0);

    // refill and request together: refill wins, request is held off
    @(negedge clk);
    req_valid = 1'b1; req_user = 4'd9; req_fluid = F_WATER; req_vol = 8'd1;
    refill_valid = 1'b1; refill_fluid = F_WATER; refill_amt = 16'hFFFF;
    #1;
    chk("combo req_ready", req_ready, 0);
    chk("combo refill_ready", refill_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; refill_valid = 1'b0;
    run_req("water_sat", 9, 0, 1, 0, 20, 0, 20, 65534, 1, 5);

    run_req("juice67", 3, 1, 67, 0, 2030, 0, 2030, 3, 1, 0);
    chk("low juice", stock_low, 3'b010);
    @(negedge clk);
    refill_valid = 1'b1; refill_fluid = F_JUICE; refill_amt = 16'd5;
    #1;
    chk("refill5 ready", refill_ready, 1);
    @(negedge clk);
    refill_valid = 1'b0;
    chk("low after refill", stock_low, 3'b010);
    run_req("juice9", 3, 1, 9, 1, 0, 0, 0, 8, 1, 0);

    // reset during the 4th litre of a 10-litre water dispense
    @(negedge clk);
    req_valid = 1'b1; req_user = 4'd5; req_fluid = F_WATER; req_vol = 8'd10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid valve_open", valve_open, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort valve_open", valve_open, 0);
    chk("abort resp_valid", resp_valid, 0);
    chk("abort stock_low", stock_low, 3'b000);
    reset = 1'b1;
    @(negedge clk);
    run_req("post_rst", 5, 0, 0, 3, 0, 0, 0, 100, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fluid_dispense_ctrl.md
Name: fluid_dispense_ctrl

Overview:
Sequential successor to the combinational fluid dispenser datapath. It accepts purchase requests over a valid/ready handshake and tracks per-user visits in saturating counters. It holds live per-fluid stock registers that decrement one litre per cycle while the valve is open, and supports refills. It returns pricing, discount and status over a valid/ready response channel, and sits between the kiosk front-end and the valve driver.

Parameters:
NUM_USERS, 16, number of user visit counters; USER_W = clog2(NUM_USERS)
VISIT_W, 4, visit counter width; counter saturates at 2^VISIT_W-1
VOL_W, 8, request volume width (litres)
PRICE_W, 16, price width
STOCK_W, 16, per-fluid stock width; STOCK_MAX = 2^STOCK_W-1
INIT_WATER / INIT_JUICE / INIT_CHEM, 100 / 80 / 60, stock value loaded at reset
LOW_THRESH, 10, stock_low asserts when stock < LOW_THRESH

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (sampled at posedge clk; 0 = reset)
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_user  in  USER_W  user id
req_fluid  in  2  00 water, 01 juice, 10 chemical, 11 invalid
req_vol  in  VOL_W  litres requested
resp_valid  out  1  response valid, held until resp_ready
resp_ready  in  1  consumer ready
resp_status  out  2  0 OK, 1 insufficient stock, 2 invalid fluid, 3 zero volume
resp_orig_price  out  PRICE_W  undiscounted price
resp_final_price  out  PRICE_W  discounted price
resp_disc  out  7  discount percent
resp_remaining  out  STOCK_W  stock of requested fluid after the transaction
resp_visits  out  VISIT_W  user visit count after the transaction
valve_open  out  1  high one cycle per litre dispensed
valve_fluid  out  2  fluid being dispensed
refill_valid  in  1  refill request
refill_ready  out  1  refill accepted when refill_valid & refill_ready
refill_fluid  in  2  fluid to refill (11 ignored)
refill_amt  in  STOCK_W  litres added
stock_low  out  3  per-fluid low-stock flags, bit index = fluid code

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all visit counters 0; stock = INIT_*. All outputs 0, except stock_low, which reflects the INIT values against LOW_THRESH.
- FSM states: IDLE -> CALC -> DISPENSE -> RESP -> IDLE. CALC -> RESP directly on any error.
- IDLE:
  - refill_ready = 1.
  - req_ready = !refill_valid; refill has priority when both are valid in the same cycle.
  - Accepted request fields are latched.
- Refill:
  - stock[f] = min(stock[f] + refill_amt, STOCK_MAX), saturating, updated the cycle after acceptance.
  - refill_fluid 11 is accepted and ignored.
- CALC (1 cycle), error checks in priority order: fluid 11 -> status 2; vol 0 -> status 3; vol > stock -> status 1.
- Price (unit rates live in the package; first-litre rate, then follow-on rate for the remaining vol-1 litres):
  - water 20 then 10; juice 50 then 30; chemical 40 then 20.
- Discount uses the visit count before increment: count <=2 -> 0%, <=4 -> 10%, else 20%.
- Final price = orig - floor(orig*disc/100), computed at PRICE_W+7 bits and truncated to PRICE_W.
- On error: prices 0, disc 0, no stock or visit change; resp_remaining = current stock (0 for fluid 11).
- DISPENSE:
  - Lasts exactly req_vol cycles; valve_open = 1 and stock decrements by 1 each cycle.
  - Visit counter increments, saturating, on entry to RESP.
- RESP: resp_* stable while resp_valid = 1; leave RESP on resp_valid & resp_ready.
- Latency: OK request accepted at cycle T -> resp_valid at T+2+vol; error -> T+2.
- No new request or refill is accepted outside IDLE.
- Reset mid-operation: abort immediately. Partial stock decrements are discarded because stock is reloaded to INIT. resp_valid and valve_open are 0 the following cycle.
- stock_low is combinational from the stock registers.

Decomposition:
- Package fluid_pkg: fluid code constants, status codes, rate table (first/follow-on per fluid), discount thresholds and percents.
- Sub-module visit_counter_bank: NUM_USERS saturating VISIT_W counters with read port (user id) and increment strobe.

Test Plan:
- Reset, then user 5, water, 3L -> valve_open 3 cycles; resp at T+5; status 0, orig 40, disc 0, final 40, remaining 97, visits 1.
- User 2 makes four successful juice 2L buys; the 4th sees prior count 3 -> orig 80, disc 10, final 72, visits 4.
- Chemical 61L at stock 60 -> status 1, prices 0, remaining 60, valve never opens, resp at T+2.
- Fluid 11, and separately water 0L -> status 2 and status 3 respectively; no visit change.
- Refill water 65535 with refill_valid and req_valid in the same IDLE cycle -> refill taken, req_ready 0 that cycle, stock saturates at 65535. Refill juice 5 from stock 3 -> 8, stock_low[1] stays 1.
- reset=0 during DISPENSE (water 10L, cycle 4) -> next cycle state IDLE, valve_open 0, stock 100, visits 0. Separately, resp_ready held 0 for 5 cycles -> resp fields stable, req_ready 0.
